bcd_7seg_mux_driver: RTL

//  Time-multiplexed 2-digit 7-segment driver. It consumes the tens/ones BCD digits from the binary-to-BCD stage and drives a shared segment bus plus one anode per digit.
//  - Holding register with a load strobe, so a mid-scan digit change cannot tear the display.
//  - Anti-ghosting guard interval at the start of each digit slot.
//  - Optional leading-zero blanking; an invalid BCD digit shows a dash.

---
 rtl/bcd_7seg_mux_if.sv | 23 ++
 rtl/bcd_7seg_mux_driver.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bcd_7seg_mux_if.sv
// Digit inputs and display outputs of the two-digit 7-segment scan driver.
// load is a single-cycle strobe with no back-pressure: on any clk edge where load = 1 the driver captures bcd_ones/bcd_tens.
interface bcd_7seg_mux_if;
  logic       enable;
  logic       load;
  logic [3:0] bcd_ones;
  logic [3:0] bcd_tens;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic       slot;
  logic [1:0] dbg_state;

  modport master (
    output enable, load, bcd_ones, bcd_tens,
    input  seg, an, dp, slot, dbg_state
  );

  modport slave (
    input  enable, load, bcd_ones, bcd_tens,
    output seg, an, dp, slot, dbg_state
  );
endinterface

// File: rtl/bcd_7seg_mux_driver.sv
// Time-multiplexed 2-digit 7-segment driver: holding register, guard-banded scan FSM,
// leading-zero blanking and dash for invalid BCD, all outputs registered.
module bcd_7seg_mux_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 64,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  bcd_7seg_mux_if.slave  bus
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] G_LAST   = CW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic          INACT    = ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          digit, digit_n;
  logic [3:0]    ones_q, tens_q;

  logic [6:0] seg_q, seg_n;
  logic [1:0] an_q, an_n;
  logic       slot_q;

  function automatic logic [6:0] seg_pattern(input logic [3:0] v);
    case (v)
      4'd0:    seg_pattern = 7'h3F;
      4'd1:    seg_pattern = 7'h06;
      4'd2:    seg_pattern = 7'h5B;
      4'd3:    seg_pattern = 7'h4F;
      4'd4:    seg_pattern = 7'h66;
      4'd5:    seg_pattern = 7'h6D;
      4'd6:    seg_pattern = 7'h7D;
      4'd7:    seg_pattern = 7'h07;
      4'd8:    seg_pattern = 7'h7F;
      4'd9:    seg_pattern = 7'h6F;
      default: seg_pattern = 7'h40;
    endcase
  endfunction

  // Captured digits only change on load, so a scan in progress never sees a half-updated pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else if (bus.load) begin
      ones_q <= bus.bcd_ones;
      tens_q <= bus.bcd_tens;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OFF;
      cnt   <= '0;
      digit <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      digit <= digit_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    digit_n = digit;
    if (!bus.enable) begin
      state_n = ST_OFF;
      cnt_n   = '0;
      digit_n = 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          cnt_n   = '0;
          digit_n = 1'b0;
          state_n = (GUARD == 0) ? ST_SHOW : ST_GUARD;
        end
        ST_GUARD: begin
          cnt_n = cnt + CW'(1);
          if (cnt == G_LAST) state_n = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            digit_n = ~digit;
            state_n = (GUARD == 0) ? ST_SHOW : ST_GUARD;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = ST_OFF;
          cnt_n   = '0;
          digit_n = 1'b0;
        end
      endcase
    end
  end

  // A blanked tens digit keeps its full slot length; only the drive is suppressed.
  always_comb begin
    logic       blank;
    logic       lit;
    logic [6:0] pat;
    logic [1:0] an_on;
    blank = BLANK_LZ && digit && (tens_q == 4'd0);
    lit   = (state == ST_SHOW) && !blank;
    pat   = seg_pattern(digit ? tens_q : ones_q);
    an_on = digit ? 2'b10 : 2'b01;
    seg_n = {7{INACT}};
    an_n  = {2{INACT}};
    if (lit) begin
      seg_n = pat ^ {7{INACT}};
      an_n  = an_on ^ {2{INACT}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q  <= {7{INACT}};
      an_q   <= {2{INACT}};
      slot_q <= 1'b0;
    end else begin
      seg_q  <= seg_n;
      an_q   <= an_n;
      slot_q <= digit;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.dp        = INACT;
  assign bus.slot      = slot_q;
  assign bus.dbg_state = state;

endmodule
